// File: rtl/cache_pkg.sv
// Shared definitions for the cacheline memory-port arbiter: line geometry
// and the arbiter state encoding.
package cache_pkg;

    localparam int ADDR_BITS   = 32;
    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;
    localparam int TAG_LSB     = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Serialises whole-line transactions from the instruction side (read-only)
// and the data side (read/write) onto one 256-bit memory port. A granted
// request is latched so the memory side only ever sees registered signals.
// Simultaneous requests are resolved by a one-flop round-robin pointer.
module cacheline_arbiter
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic [ADDR_BITS-1:0] icache_addr,
    input  logic                 icache_read,
    output logic [LINE_BITS-1:0] icache_rdata,
    output logic                 icache_resp,

    input  logic [ADDR_BITS-1:0] dcache_addr,
    input  logic                 dcache_read,
    input  logic                 dcache_write,
    input  logic [LINE_BITS-1:0] dcache_wdata,
    output logic [LINE_BITS-1:0] dcache_rdata,
    output logic                 dcache_resp,

    output logic [ADDR_BITS-1:0] mem_addr,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_resp
);

    arb_state_t                     state_reg, state_next;
    logic                           rr_prio_reg, rr_prio_next;   // 0: I preferred, 1: D preferred
    logic [ADDR_BITS-1:TAG_LSB]     lat_addr_reg, lat_addr_next;
    logic [LINE_BITS-1:0]           lat_wdata_reg, lat_wdata_next;
    logic                           lat_write_reg, lat_write_next;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic busy;

    // The byte offset of a line address carries no information here.
    logic unused_offset_bits;
    assign unused_offset_bits = &{1'b0, icache_addr[OFFSET_BITS-1:0], dcache_addr[OFFSET_BITS-1:0]};

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;

    // Exactly one side requesting wins outright; on a tie rr_prio decides.
    assign grant_i = i_req & (~d_req | ~rr_prio_reg);
    assign grant_d = d_req & (~i_req |  rr_prio_reg);

    assign busy = (state_reg == BUSY_I) || (state_reg == BUSY_D);

    // Memory port comes only from latched state, never from upstream inputs.
    assign mem_addr  = {lat_addr_reg, {OFFSET_BITS{1'b0}}};
    assign mem_read  = busy & ~lat_write_reg;
    assign mem_write = busy &  lat_write_reg;
    assign mem_wdata = lat_wdata_reg;

    // Read data is shared; only the resp pulses qualify it.
    assign icache_rdata = mem_rdata;
    assign dcache_rdata = mem_rdata;

    // Next-state, latch and response logic.
    always_comb begin
        state_next     = state_reg;
        rr_prio_next   = rr_prio_reg;
        lat_addr_next  = lat_addr_reg;
        lat_wdata_next = lat_wdata_reg;
        lat_write_next = lat_write_reg;
        icache_resp    = 1'b0;
        dcache_resp    = 1'b0;

        unique case (state_reg)
            IDLE: begin
                // mem_resp is deliberately ignored here (stray or post-reset).
                if (grant_i) begin
                    state_next     = BUSY_I;
                    lat_addr_next  = icache_addr[ADDR_BITS-1:TAG_LSB];
                    lat_write_next = 1'b0;
                end else if (grant_d) begin
                    state_next     = BUSY_D;
                    lat_addr_next  = dcache_addr[ADDR_BITS-1:TAG_LSB];
                    // A read+write collision resolves to a write.
                    lat_write_next = dcache_write;
                    lat_wdata_next = dcache_wdata;
                end
            end
            BUSY_I: begin
                if (mem_resp) begin
                    icache_resp  = 1'b1;
                    state_next   = IDLE;
                    rr_prio_next = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_resp) begin
                    dcache_resp  = 1'b1;
                    state_next   = IDLE;
                    rr_prio_next = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_prio_reg   <= 1'b0;
            lat_addr_reg  <= '0;
            lat_wdata_reg <= '0;
            lat_write_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_prio_reg   <= rr_prio_next;
            lat_addr_reg  <= lat_addr_next;
            lat_wdata_reg <= lat_wdata_next;
            lat_write_reg <= lat_write_next;
        end
    end

endmodule

// File: doc/cacheline_arbiter.md
# cacheline_arbiter

Shares the single 256-bit cacheline memory port between the instruction side (the cacheline buffer / icache, read-only) and the data side (dcache, read and write). It sits between the two cache DFP ports and the memory-side adapter. It serialises whole-line transactions, latching each granted request so the memory side sees stable signals. It uses round-robin arbitration when both sides request in the same cycle.

## Interface
Parameters:
- None. Line width is 256 bits and address width is 32 bits, both taken from the shared package.

Ports:
- clk  in  1  clock; one clock domain; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- icache_addr  in  32  I-side line address; bits [4:0] are ignored.
- icache_read  in  1  I-side read request; held until icache_resp.
- icache_rdata  out  256  line data; a direct copy of mem_rdata.
- icache_resp  out  1  I-side completion pulse.
- dcache_addr  in  32  D-side line address; bits [4:0] are ignored.
- dcache_read  in  1  D-side read request; held until dcache_resp.
- dcache_write  in  1  D-side write request; held until dcache_resp.
- dcache_wdata  in  256  D-side write line.
- dcache_rdata  out  256  line data; a direct copy of mem_rdata.
- dcache_resp  out  1  D-side completion pulse.
- mem_addr  out  32  latched line address, with [4:0] forced to 0.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- mem_wdata  out  256  latched write line.
- mem_rdata  in  256  memory read line.
- mem_resp  in  1  memory completion; one cycle per transaction.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. Registers:
  - state
  - rr_prio: 0 = I-side preferred, 1 = D-side preferred
  - lat_addr[31:5]
  - lat_wdata[255:0]
  - lat_write
- IDLE, request detection:
  - I-side request = icache_read.
  - D-side request = dcache_read | dcache_write.
  - No request: stay in IDLE.
- IDLE, grant on the next edge:
  - If exactly one side requests, that side is granted.
  - If both request, the side selected by rr_prio is granted.
- IDLE, latching at the grant edge:
  - Latch addr[31:5] from the granted side.
  - I grant: lat_write=0.
  - D grant: lat_write=dcache_write and lat_wdata=dcache_wdata.
- BUSY_x, memory drive:
  - mem_addr = {lat_addr, 5'b0}
  - mem_read = ~lat_write
  - mem_write = lat_write
  - mem_wdata = lat_wdata
  - These are driven from registers only. There is no combinational path from the upstream ports to the memory port.
- BUSY_x, completion:
  - On mem_resp, assert x_resp in the same cycle, combinationally gated by state.
  - Go to IDLE.
  - Set rr_prio to point at the other side.
- BUSY_x, waiting: without mem_resp, hold the state and keep every mem_* output unchanged.
- IDLE ignores mem_resp. This covers a stray or post-reset response: no upstream resp and no state change.
- dcache_read and dcache_write asserted together is a protocol violation. The write wins (lat_write=1).
- A requester dropping its request while granted is a protocol violation. The arbiter still completes the latched transaction, and the resp pulse is still issued.
- icache_rdata and dcache_rdata always mirror mem_rdata. Only the resp signals qualify the data.

## Timing
- Reset values:
  - state=IDLE, rr_prio=0, lat_*=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - icache_resp=0, dcache_resp=0.
- Reset mid-transaction: mem_read/mem_write are low in the cycle after the reset edge, and any in-flight mem_resp is dropped.
- Grant latency: a request first seen in IDLE at cycle N gives mem_read or mem_write high from cycle N+1.
- Response latency: mem_resp at cycle M gives x_resp at cycle M, and the FSM is in IDLE at M+1.
- Back-to-back spacing: a request still pending at M+1 is granted at the M+1 edge, with memory asserted from M+2. Minimum spacing is one idle cycle between transactions.
- The requester is expected to deassert at M+1 after its resp. A request held through M+1 is treated as a new request.
- Tie-break: under continuous contention, grants strictly alternate I, D, I, D…, starting with I after reset.

## Structure
- Shared package cache_pkg holds:
  - the arb_state_t enum (IDLE, BUSY_I, BUSY_D)
  - LINE_BITS=256
  - OFFSET_BITS=5
  - TAG_LSB=5
- The design is a single module with no sub-module. The two-way round-robin is one flop plus a mux, which is too small to split out.

## Test plan
- Reset then idle: all outputs 0; a mem_resp pulse while IDLE gives no icache_resp or dcache_resp.
- I-only read:
  - Stimulus: icache_addr=0x0000_1234, icache_read=1 at cycle 1; memory responds at cycle 5 with mem_rdata=0xA5…A5.
  - Expected: mem_addr=0x0000_1220 and mem_read=1 over cycles 2–5; icache_resp=1 only at cycle 5 with icache_rdata=0xA5…A5; IDLE at cycle 6.
- D write:
  - Stimulus: dcache_write=1, dcache_addr=0x8000_0040, dcache_wdata=0xDEAD…BEEF; dcache_wdata changes mid-transaction.
  - Expected: mem_write=1, mem_read=0, mem_wdata stays 0xDEAD…BEEF until mem_resp; dcache_resp pulses once.
- Contention:
  - Stimulus: both sides request from cycle 1 and every request is re-asserted after its resp.
  - Expected: grant order I, D, I, D; one idle cycle between transactions; neither side starves.
- Reset mid-transaction:
  - Stimulus: rst during BUSY_D, with mem_resp arriving two cycles after reset.
  - Expected: mem_write=0 the cycle after the reset edge; no dcache_resp; rr_prio=0.
- Simultaneous read and write:
  - Stimulus: dcache_read=1 and dcache_write=1 together.
  - Expected: mem_write=1, mem_read=0.
